// File: rtl/demux_collect.sv
// Serial-to-lane demultiplexer: collects steered bits into a word,
// then presents word and written-lane mask on a valid/ready output.
module demux_collect #(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             d_bit,
  input  logic [SEL_W-1:0] d_sel,
  input  logic             d_commit,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [WIDTH-1:0] q_word,
  output logic [WIDTH-1:0] q_mask,
  output logic             err_overwrite
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] smask_q, smask_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             err_q, err_d;

  logic             accept, hit, commit, drain;
  logic [WIDTH-1:0] sel_oh, wr_word, wr_mask;

  assign q_valid       = (state_q == HOLD);
  assign d_ready       = !q_valid;
  assign q_word        = word_q;
  assign q_mask        = mask_q;
  assign err_overwrite = err_q;

  assign accept = d_valid & d_ready;
  assign drain  = q_valid & q_ready;

  // Out-of-range lanes decode to an empty one-hot, so the beat is dropped
  always_comb begin
    sel_oh = '0;
    if (int'(d_sel) < WIDTH) sel_oh[d_sel] = 1'b1;
  end

  assign hit     = |(smask_q & sel_oh);
  assign wr_word = (shadow_q & ~sel_oh) | ({WIDTH{d_bit}} & sel_oh);
  assign wr_mask = smask_q | sel_oh;
  assign commit  = accept & (d_commit | (&wr_mask));

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    smask_d  = smask_q;
    word_d   = word_q;
    mask_d   = mask_q;
    err_d    = accept & hit;
    unique case (1'b1)
      commit: begin
        word_d   = wr_word;
        mask_d   = wr_mask;
        shadow_d = '0;
        smask_d  = '0;
        state_d  = HOLD;
      end
      accept & !commit: begin
        shadow_d = wr_word;
        smask_d  = wr_mask;
        state_d  = (|wr_mask) ? FILL : IDLE;
      end
      drain: begin
        state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      smask_q  <= '0;
      word_q   <= '0;
      mask_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      smask_q  <= smask_d;
      word_q   <= word_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_demux_collect.sv
// Randomized + directed bench for demux_collect with a
// transaction-level reference model and output scoreboard.
module tb_demux_collect;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_valid, d_ready, d_bit, d_commit;
  logic [2:0] d_sel;
  logic       q_valid, q_ready;
  logic [7:0] q_word, q_mask;
  logic       err_overwrite;

  int n_cmp = 0;
  int n_bad = 0;

  demux_collect #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_ready(d_ready),
    .d_bit(d_bit), .d_sel(d_sel), .d_commit(d_commit),
    .q_valid(q_valid), .q_ready(q_ready),
    .q_word(q_word), .q_mask(q_mask),
    .err_overwrite(err_overwrite)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a word under construction, a flag for an
  // outstanding output word, and a queue of expected words.
  logic [7:0]  m_word = '0;
  logic [7:0]  m_mask = '0;
  bit          m_hold = 0;
  bit          m_err  = 0;
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      m_word = '0;
      m_mask = '0;
      m_hold = 0;
      m_err  = 0;
      exp_q.delete();
    end else if (!m_hold && d_valid) begin
      m_err = m_mask[d_sel];
      m_word[d_sel] = d_bit;
      m_mask[d_sel] = 1'b1;
      if (d_commit || m_mask == 8'hFF) begin
        exp_q.push_back({m_word, m_mask});
        m_word = '0;
        m_mask = '0;
        m_hold = 1;
      end
    end else begin
      m_err = 0;
      if (m_hold && q_ready) m_hold = 0;
    end
  end

  // Monitor: samples just after each rising edge.
  bit          seen = 0;
  logic [15:0] cur;
  always @(posedge clk) begin
    #1;
    chk("d_ready", d_ready, !m_hold);
    chk("q_valid", q_valid, m_hold);
    chk("err_overwrite", err_overwrite, m_err);
    if (q_valid && !seen) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %h/%h expected none",
                 q_word, q_mask);
        cur = {q_word, q_mask};
      end else begin
        cur = exp_q.pop_front();
        chk("q_word", q_word, cur[15:8]);
        chk("q_mask", q_mask, cur[7:0]);
      end
    end else if (q_valid) begin
      chk("hold_stable", {q_word, q_mask}, cur);
    end
    seen = q_valid;
  end

  task automatic cyc(input logic v, input logic b, input logic [2:0] s,
                     input logic c, input logic qr, input logic r);
    @(negedge clk);
    d_valid  = v;
    d_bit    = b;
    d_sel    = s;
    d_commit = c;
    q_ready  = qr;
    rst      = r;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic qr, input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, qr, 0);
  endtask

  logic [7:0] pat;
  int errs;

  initial begin
    rst = 1; d_valid = 0; d_bit = 0; d_sel = 0; d_commit = 0; q_ready = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_q_valid", q_valid, 0);
    chk("rst_q_word", q_word, 0);
    chk("rst_q_mask", q_mask, 0);
    chk("rst_d_ready", d_ready, 1);
    idle(0, 1);

    // 1 auto-commit
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) cyc(1, pat[i], 3'(i), 0, 0, 0);
    chk("t1_valid", q_valid, 1);
    chk("t1_word", q_word, 8'hA5);
    chk("t1_mask", q_mask, 8'hFF);
    idle(1, 2);

    // 2 partial commit, then 3 backpressure
    errs = 0;
    cyc(1, 1, 1, 0, 0, 0); errs += err_overwrite;
    cyc(1, 1, 6, 1, 0, 0); errs += err_overwrite;
    chk("t2_word", q_word, 8'h42);
    chk("t2_mask", q_mask, 8'h42);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      errs += err_overwrite;
      chk("t3_ready_low", d_ready, 0);
      chk("t3_stable", q_word, 8'h42);
    end
    chk("t2_no_err", errs, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t3_released", q_valid, 0);
    chk("t3_ready", d_ready, 1);

    // 4 overwrite
    cyc(1, 1, 3, 0, 0, 0);
    chk("t4_no_err_yet", err_overwrite, 0);
    cyc(1, 0, 3, 1, 0, 0);
    chk("t4_err", err_overwrite, 1);
    chk("t4_word", q_word, 8'h00);
    chk("t4_mask", q_mask, 8'h08);
    idle(0, 1);
    chk("t4_err_pulse", err_overwrite, 0);
    idle(1, 2);

    // 5 reset mid-fill, and reset in HOLD
    for (int i = 0; i < 3; i++) cyc(1, 1, 3'(i), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 1, 7, 1, 0, 0);
    chk("t5_word", q_word, 8'h80);
    chk("t5_mask", q_mask, 8'h80);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t5_rst_hold", q_valid, 0);
    idle(0, 1);

    // 6 qualification
    cyc(0, 1, 2, 1, 0, 0);
    chk("t6_no_commit", q_valid, 0);
    cyc(1, 1, 2, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 3'(i + 4), 1, 0, 0);
    chk("t6_hold_word", q_word, 8'h04);
    chk("t6_hold_mask", q_mask, 8'h04);
    idle(1, 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(0, 99) < 60), 1'($urandom), 3'($urandom),
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 50),
          ($urandom_range(0, 499) == 0));
    idle(1, 3);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
